// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing FSM: FETCH/DECODE/EXEC/MEM/WB over a shared
// req/ready memory port, with retire counting and trap on illegal flags/timeout.
module multicycle_ctrl #(
    parameter int CNT_W     = 32,
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT   = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             RegWrite,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_en,
    output logic             pc_en,
    output logic             reg_we,
    output logic             busy,
    output logic             fault,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(TIMEOUT - 1);

    state_t               state_q, state_d;
    logic                 lat_read, lat_write, lat_regw;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic                 wait_inc;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            lat_read  <= 1'b0;
            lat_write <= 1'b0;
            lat_regw  <= 1'b0;
            wait_cnt  <= '0;
            instret   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                lat_read  <= MemRead;
                lat_write <= MemWrite;
                lat_regw  <= RegWrite;
            end
            // Counter only survives consecutive unanswered request cycles.
            wait_cnt <= wait_inc ? wait_cnt + 1'b1 : '0;
            if (pc_en)
                instret <= instret + 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_en    = 1'b0;
        pc_en    = 1'b0;
        reg_we   = 1'b0;
        wait_inc = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (run)
                    state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                ir_en   = mem_ready;
                if (mem_ready)
                    state_d = S_DECODE;
                else if (wait_cnt == WAIT_LAST)
                    state_d = S_FAULT;
                else
                    wait_inc = 1'b1;
            end
            S_DECODE: begin
                state_d = (MemRead && MemWrite) ? S_FAULT : S_EXEC;
            end
            S_EXEC: begin
                if (lat_read || lat_write)
                    state_d = S_MEM;
                else if (lat_regw)
                    state_d = S_WB;
                else begin
                    pc_en   = 1'b1;
                    state_d = run ? S_FETCH : S_IDLE;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = lat_write;
                if (mem_ready) begin
                    if (lat_write) begin
                        pc_en   = 1'b1;
                        state_d = run ? S_FETCH : S_IDLE;
                    end else
                        state_d = S_WB;
                end else if (wait_cnt == WAIT_LAST)
                    state_d = S_FAULT;
                else
                    wait_inc = 1'b1;
            end
            S_WB: begin
                reg_we  = 1'b1;
                pc_en   = 1'b1;
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    assign busy  = (state_q != S_IDLE) && (state_q != S_FAULT);
    assign fault = (state_q == S_FAULT);
    assign state = state_q;

endmodule
